// File: rtl/matvec_engine.sv
// Multi-lane matrix-vector multiply engine: LANES parallel MACs against an owned vector SRAM,
// matrix rows streamed in LANES-wide beats, one dot product per row on a valid/ready output.
module matvec_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int VEC_DEPTH  = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ADDR_WIDTH:0]         cfg_hdim,
    input  logic [7:0]                  cfg_vdim,
    input  logic                        cfg_signed,
    input  logic                        vec_we,
    input  logic [ADDR_WIDTH-1:0]       vec_addr,
    input  logic [LANES*DATA_WIDTH-1:0] vec_din,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [ACC_WIDTH-1:0]        out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        err
);
    localparam int VW = LANES * DATA_WIDTH;
    localparam int HW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [HW-1:0]           hdim_q, hdim_d;
    logic [7:0]              vdim_q, vdim_d;
    logic [7:0]              row_q, row_d;
    logic                    signed_q, signed_d;
    logic [ADDR_WIDTH-1:0]   col_q, col_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [ACC_WIDTH-1:0]    out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    err_q, err_d;
    logic [VW-1:0]           rd_data_q, rd_data_d;

    logic [VW-1:0]           mem [VEC_DEPTH];

    logic                    last_col;
    logic                    accept;
    logic                    pop;
    logic                    cfg_illegal;
    logic                    vec_wr;
    logic [ADDR_WIDTH-1:0]   next_col;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ACC_WIDTH-1:0]    beat_sum;
    logic [ACC_WIDTH-1:0]    row_sum;

    logic signed [DATA_WIDTH:0]     op_a [LANES];
    logic signed [DATA_WIDTH:0]     op_b [LANES];
    logic signed [2*DATA_WIDTH+1:0] prod [LANES];

    assign cfg_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE) || out_valid_q;
    assign err         = err_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;

    assign last_col    = ({1'b0, col_q} == (hdim_q - HW'(1)));
    assign in_ready    = (state_q == ST_RUN) && !(last_col && out_valid_q && !out_ready);
    assign accept      = in_valid && in_ready;
    assign pop         = out_valid_q && out_ready;
    assign vec_wr      = vec_we && !busy;
    assign cfg_illegal = (cfg_hdim == '0) || (cfg_hdim > HW'(VEC_DEPTH)) || (cfg_vdim == 8'd0);

    // Reading the upcoming column on accept keeps one beat per cycle, including across rows.
    assign next_col  = last_col ? '0 : col_q + ADDR_WIDTH'(1);
    assign rd_addr   = (state_q == ST_RUN) ? (accept ? next_col : col_q) : '0;
    assign rd_data_d = mem[rd_addr];

    // Operands widened by one bit so one signed multiplier covers both signed and unsigned jobs.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            op_a[i]  = {signed_q & in_data[i*DATA_WIDTH + DATA_WIDTH - 1],
                        in_data[i*DATA_WIDTH +: DATA_WIDTH]};
            op_b[i]  = {signed_q & rd_data_q[i*DATA_WIDTH + DATA_WIDTH - 1],
                        rd_data_q[i*DATA_WIDTH +: DATA_WIDTH]};
            prod[i]  = op_a[i] * op_b[i];
            beat_sum = beat_sum + ACC_WIDTH'(prod[i]);
        end
    end

    assign row_sum = ((col_q == '0) ? '0 : acc_q) + beat_sum;

    always_comb begin
        state_d     = state_q;
        hdim_d      = hdim_q;
        vdim_d      = vdim_q;
        signed_d    = signed_q;
        col_d       = col_q;
        row_d       = row_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !pop;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        err_d    = 1'b0;
                        hdim_d   = cfg_hdim;
                        vdim_d   = cfg_vdim;
                        signed_d = cfg_signed;
                        col_d    = '0;
                        row_d    = '0;
                        acc_d    = '0;
                        state_d  = ST_PREFETCH;
                    end
                end
            end
            ST_PREFETCH: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (accept) begin
                    if (last_col) begin
                        out_data_d  = row_sum;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        col_d       = '0;
                        row_d       = row_q + 8'd1;
                        if (row_q == (vdim_q - 8'd1)) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        acc_d = row_sum;
                        col_d = col_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (vec_we && busy) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hdim_q      <= '0;
            vdim_q      <= '0;
            signed_q    <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            hdim_q      <= hdim_d;
            vdim_q      <= vdim_d;
            signed_q    <= signed_d;
            col_q       <= col_d;
            row_q       <= row_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Vector storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (vec_wr) begin
            mem[vec_addr] <= vec_din;
        end
    end

endmodule

// File: tb/tb_matvec_engine.sv
// Directed bench for matvec_engine: a 32-bit accumulator instance plus an 18-bit one
// sharing the same stimulus to exercise accumulator wrap.
module tb_matvec_engine;
    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [4:0]  cfg_hdim;
    logic [7:0]  cfg_vdim;
    logic        cfg_signed;
    logic        vec_we;
    logic [3:0]  vec_addr;
    logic [31:0] vec_din;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        err;

    logic        cfg_ready_w;
    logic        in_ready_w;
    logic [17:0] out_data_w;
    logic        out_valid_w;
    logic        busy_w;
    logic        err_w;

    int checks;
    int errors;

    logic [31:0] got_q[$];
    logic [17:0] got_w_q[$];

    matvec_engine #(
        .DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(32), .VEC_DEPTH(16), .ADDR_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_hdim(cfg_hdim), .cfg_vdim(cfg_vdim), .cfg_signed(cfg_signed),
        .vec_we(vec_we), .vec_addr(vec_addr), .vec_din(vec_din),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err(err)
    );

    matvec_engine #(
        .DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(18), .VEC_DEPTH(16), .ADDR_WIDTH(4)
    ) dut_w (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_w),
        .cfg_hdim(cfg_hdim), .cfg_vdim(cfg_vdim), .cfg_signed(cfg_signed),
        .vec_we(vec_we), .vec_addr(vec_addr), .vec_din(vec_din),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_w),
        .out_data(out_data_w), .out_valid(out_valid_w), .out_ready(out_ready),
        .busy(busy_w), .err(err_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every handshake that completes at the following rising edge.
    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (out_valid_w && out_ready) got_w_q.push_back(out_data_w);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic write_vec(input logic [3:0] a, input logic [31:0] d);
        vec_we   = 1'b1;
        vec_addr = a;
        vec_din  = d;
        @(negedge clk);
        vec_we   = 1'b0;
    endtask

    task automatic start_job(input logic [4:0] h, input logic [7:0] v, input logic s);
        cfg_valid  = 1'b1;
        cfg_hdim   = h;
        cfg_vdim   = v;
        cfg_signed = s;
        @(negedge clk);
        cfg_valid  = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d);
        logic got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50 && !got; k++) begin
            #1;
            got = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL send_beat_timeout in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b exp 1", cfg_ready); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %0d exp 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        @(negedge clk);

        // Abort a 4x4 job in the middle of its first row.
        for (int a = 0; a < 4; a++) write_vec(4'(a), 32'h01010101);
        got_q.delete();
        start_job(5'd4, 8'd4, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h02020202;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b exp 0", in_ready); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL midrst_cfg_ready got %b exp 1", cfg_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL postrst_in_ready got %b exp 0", in_ready); end
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL postrst_no_output got %0d results exp 0", got_q.size()); end
    endtask

    task automatic test_unsigned();
        write_vec(4'd0, {8'd4, 8'd3, 8'd2, 8'd1});
        write_vec(4'd1, {8'd8, 8'd7, 8'd6, 8'd5});
        got_q.delete();
        start_job(5'd2, 8'd2, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = (i < 2) ? 32'h01010101 : 32'h02020202;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL unsigned_stream_in_ready beat %0d got %b exp 1", i, in_ready); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL unsigned_count got %0d exp 2", got_q.size());
        end else begin
            checks++; if (got_q[0] !== 32'd36) begin errors++; $display("FAIL unsigned_row0 got %0d exp 36", got_q[0]); end
            checks++; if (got_q[1] !== 32'd72) begin errors++; $display("FAIL unsigned_row1 got %0d exp 72", got_q[1]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL unsigned_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_signed();
        write_vec(4'd0, {8'h04, 8'hFD, 8'h02, 8'hFF});
        got_q.delete();
        start_job(5'd1, 8'd1, 1'b1);
        send_beat({8'h01, 8'h01, 8'h01, 8'hFF});
        repeat (2) @(negedge clk);
        start_job(5'd1, 8'd1, 1'b0);
        send_beat({8'h01, 8'h01, 8'h01, 8'hFF});
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL signed_count got %0d exp 2", got_q.size());
        end else begin
            // (-1)(-1)+2-3+4 = 4 ; 255*255+2+253+4 = 65284
            checks++; if (got_q[0] !== 32'h00000004) begin errors++; $display("FAIL signed_dot got %h exp 00000004", got_q[0]); end
            checks++; if (got_q[1] !== 32'h0000FF04) begin errors++; $display("FAIL unsigned_dot got %h exp 0000ff04", got_q[1]); end
        end
    endtask

    task automatic test_backpressure();
        logic stable_ok;
        write_vec(4'd0, 32'h01010101);
        got_q.delete();
        out_ready = 1'b0;
        start_job(5'd1, 8'd3, 1'b0);
        send_beat(32'h01010101);
        in_valid  = 1'b1;
        in_data   = 32'h02020202;
        stable_ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'd4) stable_ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (stable_ok !== 1'b1) begin
            errors++; $display("FAIL bp_hold in_ready=%b out_valid=%b out_data=%0d exp 0/1/4", in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b exp 1", in_ready); end
        @(negedge clk);
        send_beat(32'h03030303);
        repeat (3) @(negedge clk);
        checks++;
        if (got_q.size() != 3) begin
            errors++; $display("FAIL bp_count got %0d exp 3", got_q.size());
        end else begin
            checks++; if (got_q[0] !== 32'd4) begin errors++; $display("FAIL bp_res0 got %0d exp 4", got_q[0]); end
            checks++; if (got_q[1] !== 32'd8) begin errors++; $display("FAIL bp_res1 got %0d exp 8", got_q[1]); end
            checks++; if (got_q[2] !== 32'd12) begin errors++; $display("FAIL bp_res2 got %0d exp 12", got_q[2]); end
        end
    endtask

    task automatic test_errors();
        got_q.delete();
        start_job(5'd0, 8'd1, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_hdim0 got %b exp 1", err); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL err_stays_idle cfg_ready got %b exp 1", cfg_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy got %b exp 0", busy); end
        repeat (3) @(negedge clk);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL err_no_output got %0d exp 0", got_q.size()); end

        write_vec(4'd0, {8'd4, 8'd3, 8'd2, 8'd1});
        start_job(5'd1, 8'd1, 1'b0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear_on_cfg got %b exp 0", err); end
        @(negedge clk);
        write_vec(4'd0, 32'hFFFFFFFF);
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_vec_we_busy got %b exp 1", err); end
        send_beat(32'h01010101);
        repeat (2) @(negedge clk);
        start_job(5'd1, 8'd1, 1'b0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear_again got %b exp 0", err); end
        send_beat(32'h01010101);
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL err_count got %0d exp 2", got_q.size());
        end else begin
            checks++; if (got_q[0] !== 32'd10) begin errors++; $display("FAIL err_sram_kept0 got %0d exp 10", got_q[0]); end
            checks++; if (got_q[1] !== 32'd10) begin errors++; $display("FAIL err_sram_kept1 got %0d exp 10", got_q[1]); end
        end
    endtask

    task automatic test_wrap();
        for (int a = 0; a < 16; a++) write_vec(4'(a), 32'hFFFFFFFF);
        got_q.delete();
        got_w_q.delete();
        start_job(5'd16, 8'd1, 1'b0);
        for (int b = 0; b < 16; b++) send_beat(32'hFFFFFFFF);
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != 1 || got_w_q.size() != 1) begin
            errors++; $display("FAIL wrap_count got %0d/%0d exp 1/1", got_q.size(), got_w_q.size());
        end else begin
            // 64 * 65025 = 4161600 ; mod 2^18 = 229440
            checks++; if (got_q[0] !== 32'd4161600) begin errors++; $display("FAIL wrap_wide got %0d exp 4161600", got_q[0]); end
            checks++; if (got_w_q[0] !== 18'd229440) begin errors++; $display("FAIL wrap_18bit got %0d exp 229440", got_w_q[0]); end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_hdim   = '0;
        cfg_vdim   = '0;
        cfg_signed = 1'b0;
        vec_we     = 1'b0;
        vec_addr   = '0;
        vec_din    = '0;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;

        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_errors();
        test_wrap();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
